// File: rtl/chrono_prescaler.sv
// Programmable, pausable tick prescaler with periodic and one-shot modes.
// Define CHRONO_PRESCALER_TICK_COUNT_EN to build the tick_count register.
module chrono_prescaler #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 5000000,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   input  logic                 oneshot,
   input  logic [WIDTH-1:0]     div_in,
   input  logic                 div_load,
   output logic                 tick,
   output logic [CNT_WIDTH-1:0] tick_count,
   output logic                 running,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_RST =
      (DEFAULT_DIV == 0) ? ONE : WIDTH'(DEFAULT_DIV);

   state_t           state;
   logic [WIDTH-1:0] phase;
   logic [WIDTH-1:0] div_act;
   logic [WIDTH-1:0] div_pend;
   logic             mode_os;
   logic             term;

   // Terminal count only fires when no command overrides the RUN cycle.
   always_comb begin
      term = 1'b0;
      if (state == RUN && !start && !stop && phase == div_act)
         term = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_pend <= DIV_RST;
      else if (div_load)
         div_pend <= (div_in == '0) ? ONE : div_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         phase   <= ONE;
         div_act <= DIV_RST;
         mode_os <= 1'b0;
         tick    <= 1'b0;
      end else if (clear) begin
         state <= IDLE;
         phase <= ONE;
         tick  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               tick <= 1'b0;
               if (start) begin
                  state   <= RUN;
                  phase   <= ONE;
                  div_act <= div_pend;
                  mode_os <= oneshot;
               end
            end
            RUN: begin
               if (start) begin
                  phase   <= ONE;
                  div_act <= div_pend;
                  mode_os <= oneshot;
                  tick    <= 1'b0;
               end else if (stop) begin
                  state <= PAUSE;
                  tick  <= 1'b0;
               end else if (term) begin
                  tick    <= 1'b1;
                  phase   <= ONE;
                  div_act <= div_pend;
                  if (mode_os)
                     state <= DONE;
               end else begin
                  phase <= phase + ONE;
                  tick  <= 1'b0;
               end
            end
            PAUSE: begin
               tick <= 1'b0;
               if (start)
                  state <= RUN;
            end
            default: begin
               state <= IDLE;
               tick  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CHRONO_PRESCALER_TICK_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tick_count <= '0;
      else if (clear)
         tick_count <= '0;
      else if (term)
         tick_count <= tick_count + CNT_WIDTH'(1);
   end
`else
   assign tick_count = '0;
`endif

   assign running = (state == RUN);
   assign done    = (state == DONE);

endmodule

// File: tb/tb_chrono_prescaler.sv
// Scoreboard bench for chrono_prescaler: expected tick edges and counts
// are queued as stimulus is applied and popped when tick is seen.
module tb_chrono_prescaler;

   localparam int W  = 32;
   localparam int CW = 2;
`ifdef CHRONO_PRESCALER_TICK_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic          clear;
   logic          oneshot;
   logic [W-1:0]  div_in;
   logic          div_load;
   logic          tick;
   logic [CW-1:0] tick_count;
   logic          running;
   logic          done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int            at;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   chrono_prescaler #(
      .WIDTH(W),
      .DEFAULT_DIV(5000000),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .clear(clear),
      .oneshot(oneshot),
      .div_in(div_in),
      .div_load(div_load),
      .tick(tick),
      .tick_count(tick_count),
      .running(running),
      .done(done)
   );

   function automatic logic [CW-1:0] ecnt(input int n);
      logic [CW-1:0] v;
      v = CW'(n);
      return CNT_EN ? v : '0;
   endfunction

   task automatic push(input int at, input int n);
      exp_t x;
      x.at  = at;
      x.cnt = ecnt(n);
      q.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start    = 1'b0;
      stop     = 1'b0;
      clear    = 1'b0;
      oneshot  = 1'b0;
      div_load = 1'b0;
      div_in   = '0;
   endtask

   task automatic load_div(input int d);
      div_in   = W'(d);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      step();
      checks++;
      if (tick !== 1'b0) begin
         failures++;
         $display("FAIL reset_tick got=%b exp=0", tick);
      end
      checks++;
      if (tick_count !== '0) begin
         failures++;
         $display("FAIL reset_count got=%0d exp=0", tick_count);
      end
      checks++;
      if ({running, done} !== 2'b00) begin
         failures++;
         $display("FAIL reset_state got=%b exp=00", {running, done});
      end
      start = 1'b1;
      step();
      start = 1'b0;
      seen = 0;
      repeat (30) begin
         step();
         if (tick) seen++;
      end
      checks++;
      if (seen !== 0 || running !== 1'b1) begin
         failures++;
         $display("FAIL reset_default_div ticks=%0d running=%b exp=0/1",
                  seen, running);
      end
      do_clear();
   endtask

   task automatic test_periodic();
      exp_t x;
      load_div(4);
      start = 1'b1;
      step();
      start = 1'b0;
      push(4, 1);
      push(8, 2);
      push(12, 3);
      for (int e = 1; e <= 13; e++) begin
         step();
         checks++;
         if (running !== 1'b1) begin
            failures++;
            $display("FAIL periodic_running e=%0d got=%b exp=1", e, running);
         end
         if (tick) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL periodic_tick spurious at edge %0d", e);
            end else begin
               x = q.pop_front();
               if (x.at !== e || tick_count !== x.cnt) begin
                  failures++;
                  $display("FAIL periodic_tick edge=%0d cnt=%0d exp edge=%0d cnt=%0d",
                           e, tick_count, x.at, x.cnt);
               end
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL periodic_missing got=%0d left exp=0", q.size());
      end
      do_clear();
   endtask

   task automatic test_pause();
      exp_t x;
      load_div(5);
      start = 1'b1;
      step();
      start = 1'b0;
      push(8, 1);
      push(13, 2);
      push(20, 3);
      for (int e = 1; e <= 21; e++) begin
         stop  = (e == 3 || e == 4 || e == 18);
         start = (e == 5 || e == 19);
         step();
         stop  = 1'b0;
         start = 1'b0;
         if (e == 3 || e == 4 || e == 5) begin
            checks++;
            if (dut.phase !== W'(3) || running !== (e == 5)) begin
               failures++;
               $display("FAIL pause_hold e=%0d phase=%0d run=%b exp 3/%b",
                        e, dut.phase, running, (e == 5));
            end
         end
         if (e == 18) begin
            checks++;
            if (dut.phase !== W'(5) || running !== 1'b0) begin
               failures++;
               $display("FAIL pause_term phase=%0d run=%b exp 5/0",
                        dut.phase, running);
            end
         end
         if (tick) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL pause_tick spurious at edge %0d", e);
            end else begin
               x = q.pop_front();
               if (x.at !== e || tick_count !== x.cnt) begin
                  failures++;
                  $display("FAIL pause_tick edge=%0d cnt=%0d exp edge=%0d cnt=%0d",
                           e, tick_count, x.at, x.cnt);
               end
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL pause_missing got=%0d left exp=0", q.size());
      end
      do_clear();
   endtask

   task automatic test_oneshot();
      exp_t x;
      logic [1:0] rd;
      load_div(4);
      oneshot = 1'b1;
      start   = 1'b1;
      step();
      start   = 1'b0;
      oneshot = 1'b0;
      push(4, 1);
      for (int e = 1; e <= 24; e++) begin
         step();
         rd = (e < 4) ? 2'b10 : 2'b01;
         checks++;
         if ({running, done} !== rd) begin
            failures++;
            $display("FAIL oneshot_state e=%0d got=%b exp=%b",
                     e, {running, done}, rd);
         end
         if (tick) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL oneshot_tick spurious at edge %0d", e);
            end else begin
               x = q.pop_front();
               if (x.at !== e || tick_count !== x.cnt) begin
                  failures++;
                  $display("FAIL oneshot_tick edge=%0d cnt=%0d exp edge=%0d cnt=%0d",
                           e, tick_count, x.at, x.cnt);
               end
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL oneshot_missing got=%0d left exp=0", q.size());
      end
      do_clear();
   endtask

   task automatic test_div_change();
      exp_t x;
      load_div(6);
      start = 1'b1;
      step();
      start = 1'b0;
      push(6, 1);
      push(8, 2);
      push(10, 3);
      push(12, 4);
      push(14, 5);
      push(15, 6);
      push(16, 7);
      push(17, 8);
      push(18, 9);
      for (int e = 1; e <= 18; e++) begin
         div_load = (e == 2 || e == 13);
         div_in   = (e == 2) ? W'(2) : '0;
         step();
         div_load = 1'b0;
         if (tick) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL divchg_tick spurious at edge %0d", e);
            end else begin
               x = q.pop_front();
               if (x.at !== e || tick_count !== x.cnt) begin
                  failures++;
                  $display("FAIL divchg_tick edge=%0d cnt=%0d exp edge=%0d cnt=%0d",
                           e, tick_count, x.at, x.cnt);
               end
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL divchg_missing got=%0d left exp=0", q.size());
      end
      do_clear();
   endtask

   task automatic test_clear_start();
      int seen;
      load_div(1);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      checks++;
      if (tick !== 1'b1 || tick_count !== ecnt(3)) begin
         failures++;
         $display("FAIL clrst_pre tick=%b cnt=%0d exp 1/%0d",
                  tick, tick_count, ecnt(3));
      end
      clear = 1'b1;
      start = 1'b1;
      step();
      clear = 1'b0;
      start = 1'b0;
      checks++;
      if ({tick, running, done} !== 3'b000 || tick_count !== '0) begin
         failures++;
         $display("FAIL clrst_after trd=%b cnt=%0d exp 000/0",
                  {tick, running, done}, tick_count);
      end
      seen = 0;
      repeat (5) begin
         step();
         if (tick || running) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL clrst_idle got=%0d active cycles exp=0", seen);
      end
      do_clear();
   endtask

   task automatic test_async_reset();
      load_div(1);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      checks++;
      if (tick !== 1'b1 || running !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre tick=%b run=%b exp 1/1", tick, running);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({tick, running, done} !== 3'b000 || tick_count !== '0 ||
          dut.phase !== W'(1)) begin
         failures++;
         $display("FAIL arst_now trd=%b cnt=%0d phase=%0d exp 000/0/1",
                  {tick, running, done}, tick_count, dut.phase);
      end
      #1;
      rst = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_periodic();
      test_pause();
      test_oneshot();
      test_div_change();
      test_clear_start();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
